keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Producer side of the 4-bit keypad bus consumed by the security controller.
- Scans a 4x4 passive matrix keypad (active-low columns driven, active-low rows read) and debounces contacts.
- Rejects multi-key presses.
- Presents a stable 4-bit key code level, a key-held flag and a one-cycle new-key strobe.
- Sits between the keypad pins and the security controller's keypad input.

Parameters:
- SCAN_DIV, 4: clk cycles each column is driven low; must be >= 3 (covers 2-flop row sync).
- DEBOUNCE_FRAMES, 3: consecutive identical full-scan frames needed to accept a press or a release; >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- row_n  input  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- col_n  output  4  column drives, active-low one-hot.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}; retained after release.
- key_down  output  1  high while the accepted key is held (debounced).
- key_valid  output  1  one-cycle pulse on each newly accepted press.
- keypad_out  output  4  key_code while key_down, else 4'b0000; drives the controller's keypad bus.

Behaviour:
- Reset values: col_n=4'b1110, key_code=0, key_down=0, key_valid=0, keypad_out=0, FSM IDLE, all counters 0. Reset mid-operation aborts any debounce silently, with no key_valid.
- row_n passes through a 2-flop synchronizer before use.
- Column slot: col_n holds one column low for SCAN_DIV cycles, ordered col0..col3, then wraps to col0. Slot counter wraps SCAN_DIV-1 -> 0.
- Sampling: synced rows are sampled on the last cycle of each slot. A low row r in column c is a contact at code {r,c}.
- Frame: 4 slots = 4*SCAN_DIV cycles. At the frame-end edge (last cycle of the col3 slot) the frame result is classified:
  - NONE: zero contacts.
  - SINGLE(code): exactly one contact.
  - MULTI: two or more contacts, in the same or different columns.
  - Per-frame contact tally is then cleared.
- FSM evaluates only at frame-end edges; between frame ends it holds state.
- IDLE:
  - SINGLE(c): cand<=c, cnt<=1, go DEBOUNCE. If DEBOUNCE_FRAMES==1, accept immediately instead.
  - NONE or MULTI: stay.
- DEBOUNCE:
  - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept.
  - Anything else: cnt<=0, go IDLE, nothing emitted.
- Accept (on that same edge): key_code<=cand, key_down<=1, key_valid<=1 for exactly the next cycle, cnt<=0, go HELD.
- HELD:
  - SINGLE(key_code): stay.
  - Otherwise (NONE, MULTI, different key): cnt<=1, go RELEASE. If DEBOUNCE_FRAMES==1, release immediately.
- RELEASE:
  - SINGLE(key_code): cnt<=0, back to HELD. No new key_valid.
  - Otherwise: cnt+1. When cnt reaches DEBOUNCE_FRAMES, release.
- Release: key_down<=0, go IDLE. key_code keeps its value; keypad_out becomes 0 on the same edge.
- Key change without a full release (A held, then B while A is still down) releases A first, then needs DEBOUNCE_FRAMES clean frames of B from IDLE.
- Latency (press): from first frame containing a stable press to key_valid = DEBOUNCE_FRAMES frames, plus up to 1 frame of alignment and 2 sync cycles.
- Code 4'b0000 (row0,col0) is indistinguishable from idle on keypad_out; consumers needing it use key_down.
- Counters: slot $clog2(SCAN_DIV) bits; cnt $clog2(DEBOUNCE_FRAMES+1) bits; no overflow, since cnt saturates at DEBOUNCE_FRAMES by construction.

Decomposition:
- Shared package keypad_pkg:
  - FSM state typedef: IDLE, DEBOUNCE, HELD, RELEASE.
  - Frame-result enum: NONE, SINGLE, MULTI.
  - Constants KEY_ARM=4'b0011, KEY_DISARM=4'b1100 and NO_KEY=4'b0000, shared with the security controller.
- Sub-module keypad_frame_scan contains:
  - row synchronizer, slot counter and col_n driver;
  - contact tally;
  - frame-end pulse plus frame result/code outputs.
- The top holds the debounce FSM and output registers.

Test Plan:
(SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles; bench models the matrix: row_n[r]=0 iff col_n[c]==0 and key(r,c) pressed.)
1. Reset: rst high mid-scan -> col_n=4'b1110, all outputs 0; after release col_n steps 1110,1101,1011,0111 every 4 cycles.
2. Clean press: hold key(0,3) for 10 frames -> exactly one key_valid pulse; key_code=4'b0011, keypad_out=4'b0011, key_down=1 within 4 frames + 2 cycles of the press.
3. Release: release key(0,3) -> key_down=0 and keypad_out=0 after 3 to 4 frames; key_code stays 4'b0011; no key_valid.
4. Bounce: toggle key(3,0) every 20 cycles for 8 frames, then hold -> no key_valid during bouncing; single pulse with key_code=4'b1100 after the stable hold.
5. Multi-key: press (0,3) and (3,0) together for 10 frames -> no key_valid, keypad_out stays 0. Then release (3,0) -> accept 4'b0011.
6. Release glitch: while HELD on 4'b1100, open the contact for exactly 1 frame -> key_down stays 1, no second key_valid. Then assert rst mid-DEBOUNCE of a new key -> no key_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Types and constants shared by the keypad scanner and the security controller.
//   kp_state_e  : debounce FSM states
//   frame_res_e : classification of one full four-column scan frame
//   KEY_ARM / KEY_DISARM / NO_KEY : key codes agreed with the controller
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      RELEASE
   } kp_state_e;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_res_e;

   localparam logic [3:0] KEY_ARM    = 4'b0011;
   localparam logic [3:0] KEY_DISARM = 4'b1100;
   localparam logic [3:0] NO_KEY     = 4'b0000;

endpackage

// File: rtl/keypad_frame_scan.sv
// -----------------------------------------------------------------------------
// keypad_frame_scan
// Drives the keypad columns one at a time, samples the synchronised rows at
// the end of every column slot and classifies each full scan frame.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   row_n[3:0]  : raw keypad rows, active-low, asynchronous to clk
//   col_n[3:0]  : active-low one-hot column drive
//   frame_end   : high on the last cycle of the column-3 slot
//   frame_res   : NONE / SINGLE / MULTI for the frame ending this cycle
//   frame_code  : {row, col} of the contact when frame_res is SINGLE
// frame_res and frame_code are only meaningful while frame_end is high.
// -----------------------------------------------------------------------------
module keypad_frame_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       frame_end,
   output frame_res_e frame_res,
   output logic [3:0] frame_code
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

   logic [3:0]    row_meta_q, row_sync_q;
   logic [SW-1:0] slot_q, slot_d;
   logic [1:0]    col_q, col_d;
   // Contact tally saturates at 2: anything above one contact is MULTI.
   logic [1:0]    tally_q, tally_d;
   logic [3:0]    code_q, code_d;

   logic          slot_last;
   logic [2:0]    col_hits;
   logic [1:0]    hit_row;
   logic [2:0]    tally_sum;
   logic [1:0]    tally_next;
   logic [3:0]    code_next;

   // Only one column is ever driven low.
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_n[gi] = (col_q != 2'(gi));
   end

   always_comb begin
      slot_last = (slot_q == SLOT_LAST);
      frame_end = slot_last && (col_q == 2'd3);

      col_hits = 3'd0;
      hit_row  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync_q[r]) begin
            col_hits = col_hits + 3'd1;
            hit_row  = 2'(r);
         end
      end

      // Fold in the current column so the frame-end cycle sees column 3.
      tally_sum  = {1'b0, tally_q} + col_hits;
      tally_next = (tally_sum >= 3'd2) ? 2'd2 : tally_sum[1:0];
      code_next  = (col_hits == 3'd1) ? {hit_row, col_q} : code_q;

      unique case (tally_next)
         2'd0:    frame_res = NONE;
         2'd1:    frame_res = SINGLE;
         default: frame_res = MULTI;
      endcase
      frame_code = code_next;

      slot_d  = slot_last ? '0 : slot_q + SW'(1);
      col_d   = slot_last ? col_q + 2'd1 : col_q;
      tally_d = tally_q;
      code_d  = code_q;
      if (slot_last) begin
         tally_d = frame_end ? 2'd0 : tally_next;
         code_d  = frame_end ? 4'd0 : code_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         slot_q     <= '0;
         col_q      <= 2'd0;
         tally_q    <= 2'd0;
         code_q     <= 4'd0;
      end else begin
         row_meta_q <= row_n;
         row_sync_q <= row_meta_q;
         slot_q     <= slot_d;
         col_q      <= col_d;
         tally_q    <= tally_d;
         code_q     <= code_d;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad front end: scans, debounces over whole frames, rejects
// multi-key presses and presents the accepted key to the security controller.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   row_n[3:0]      : keypad rows, active-low, asynchronous
//   col_n[3:0]      : column drives, active-low one-hot
//   key_code[3:0]   : last accepted key {row, col}, kept after release
//   key_down        : debounced "accepted key is held"
//   key_valid       : one-cycle pulse per newly accepted press
//   keypad_out[3:0] : key_code while key_down, else NO_KEY
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_down,
   output logic       key_valid,
   output logic [3:0] keypad_out
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

   logic       frame_end;
   frame_res_e frame_res;
   logic [3:0] frame_code;

   kp_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_down_q, key_down_d;
   logic          key_valid_q, key_valid_d;

   logic          is_single;
   logic          do_accept;
   logic          do_release;

   keypad_frame_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk        (clk),
      .rst        (rst),
      .row_n      (row_n),
      .col_n      (col_n),
      .frame_end  (frame_end),
      .frame_res  (frame_res),
      .frame_code (frame_code)
   );

   assign is_single = (frame_res == SINGLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_down_d  = key_down_q;
      key_valid_d = 1'b0;
      do_accept   = 1'b0;
      do_release  = 1'b0;

      if (frame_end) begin
         unique case (state_q)
            IDLE: begin
               if (is_single) begin
                  cand_d = frame_code;
                  if (DEBOUNCE_FRAMES == 1) begin
                     do_accept = 1'b1;
                  end else begin
                     cnt_d   = CNT_ONE;
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               // A different single key aborts too; it must restart from IDLE.
               if (is_single && (frame_code == cand_q)) begin
                  if (cnt_q == CNT_LAST) begin
                     do_accept = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (!(is_single && (frame_code == key_code_q))) begin
                  if (DEBOUNCE_FRAMES == 1) begin
                     do_release = 1'b1;
                  end else begin
                     cnt_d   = CNT_ONE;
                     state_d = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (is_single && (frame_code == key_code_q)) begin
                  cnt_d   = '0;
                  state_d = HELD;
               end else if (cnt_q == CNT_LAST) begin
                  do_release = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         endcase
      end

      if (do_accept) begin
         key_code_d  = cand_d;
         key_down_d  = 1'b1;
         key_valid_d = 1'b1;
         cnt_d       = '0;
         state_d     = HELD;
      end
      if (do_release) begin
         key_down_d = 1'b0;
         cnt_d      = '0;
         state_d    = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'd0;
         key_code_q  <= NO_KEY;
         key_down_q  <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_down_q  <= key_down_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign key_code   = key_code_q;
   assign key_down   = key_down_q;
   assign key_valid  = key_valid_q;
   // Code 0000 looks like "no key" here; consumers needing it watch key_down.
   assign keypad_out = key_down_q ? key_code_q : NO_KEY;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Models the passive key matrix, keeps a frame-level behavioural model of the
// scanner and compares every DUT output on every cycle, plus directed
// scenario checks with literal expectations.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DF = 3;
   localparam int FR = 4 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_down;
   logic        key_valid;
   logic [3:0]  keypad_out;
   logic [15:0] keys = 16'h0000;   // keys[r*4+c] = key (r,c) pressed

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV        (SD),
      .DEBOUNCE_FRAMES (DF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row_n      (row_n),
      .col_n      (col_n),
      .key_code   (key_code),
      .key_down   (key_down),
      .key_valid  (key_valid),
      .keypad_out (keypad_out)
   );

   // Passive matrix: a row is pulled low through any closed key whose
   // column is currently driven low.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_n[r] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_n;            // clock edges since reset release
   logic [15:0] m_k1, m_k2;     // key state one and two edges ago
   int          m_tally;
   logic [3:0]  m_fcode;
   int          m_run;          // consecutive clean frames of one key while up
   logic [3:0]  m_run_code;
   int          m_rel;          // consecutive frames without the held key
   logic [3:0]  m_code;
   logic        m_down;
   logic        m_valid;
   int          m_slot, m_col;
   logic        m_single;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_n = 0; m_k1 = '0; m_k2 = '0; m_tally = 0; m_fcode = '0;
         m_run = 0; m_run_code = '0; m_rel = 0;
         m_code = '0; m_down = 1'b0; m_valid = 1'b0;
      end else begin
         m_n++;
         m_slot  = int'((m_n - 1) % SD);
         m_col   = int'(((m_n - 1) / SD) % 4);
         m_valid = 1'b0;
         if (m_slot == SD - 1) begin
            // The row synchroniser means this sample reflects keys two edges ago.
            for (int r = 0; r < 4; r++) begin
               if (m_k2[r*4+m_col]) begin
                  m_tally++;
                  m_fcode = 4'(r*4 + m_col);
               end
            end
            if (m_col == 3) begin
               m_single = (m_tally == 1);
               if (!m_down) begin
                  if (m_single && (m_run == 0 || m_fcode == m_run_code)) begin
                     m_run++;
                     m_run_code = m_fcode;
                  end else begin
                     m_run = 0;
                  end
                  if (m_run == DF) begin
                     m_code = m_run_code; m_down = 1'b1; m_valid = 1'b1;
                     m_run = 0; m_rel = 0;
                  end
               end else begin
                  if (m_single && m_fcode == m_code) m_rel = 0;
                  else m_rel++;
                  if (m_rel == DF) begin
                     m_down = 1'b0; m_rel = 0; m_run = 0;
                  end
               end
               m_tally = 0;
            end
         end
         m_k2 = m_k1;
         m_k1 = keys;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [3:0] exp_col;
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_col_n", {28'd0, col_n}, 32'h0000000E);
         chk("rst_key_code", {28'd0, key_code}, 32'd0);
         chk("rst_key_down", {31'd0, key_down}, 32'd0);
         chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
         chk("rst_keypad_out", {28'd0, keypad_out}, 32'd0);
      end else begin
         exp_col = 4'b1111 ^ (4'b0001 << ((m_n / SD) % 4));
         chk("col_n", {28'd0, col_n}, {28'd0, exp_col});
         chk("key_code", {28'd0, key_code}, {28'd0, m_code});
         chk("key_down", {31'd0, key_down}, {31'd0, m_down});
         chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
         chk("keypad_out", {28'd0, keypad_out}, {28'd0, (m_down ? m_code : 4'd0)});
      end
   end

   always @(negedge clk) begin
      if (!rst && key_valid === 1'b1) begin
         valid_cnt++;
         $display("accept: key_code=%b at %0t", key_code, $time);
      end
   end

   // ---------------- stimulus ----------------
   int  v0;
   int  lat;
   logic seen;
   logic all_down;
   logic any_out;
   int  hold;
   int  k1, k2;

   initial begin
      rst  = 1'b1;
      keys = '0;
      tick(3);
      rst = 1'b0;

      // 1. Reset mid-scan, then column stepping.
      tick(7);
      rst = 1'b1;
      #1;
      chk("t1_async_col_n", {28'd0, col_n}, 32'h0000000E);
      chk("t1_async_key_down", {31'd0, key_down}, 32'd0);
      tick(2);
      rst = 1'b0;
      chk("t1_col0", {28'd0, col_n}, 32'h0000000E);
      tick(4); chk("t1_col1", {28'd0, col_n}, 32'h0000000D);
      tick(4); chk("t1_col2", {28'd0, col_n}, 32'h0000000B);
      tick(4); chk("t1_col3", {28'd0, col_n}, 32'h00000007);
      tick(4); chk("t1_wrap", {28'd0, col_n}, 32'h0000000E);
      $display("txn: reset and column scan done");

      // 2. Clean press of (0,3).
      v0 = valid_cnt;
      keys[3] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4*FR + 2 && !seen; i++) begin
         tick(1);
         seen = key_down;
      end
      chk("t2_down_in_time", {31'd0, seen}, 32'd1);
      tick(8*FR);
      chk("t2_one_valid", valid_cnt - v0, 32'd1);
      chk("t2_key_code", {28'd0, key_code}, 32'h3);
      chk("t2_keypad_out", {28'd0, keypad_out}, 32'h3);
      $display("txn: press (0,3)");

      // 3. Release of (0,3).
      v0 = valid_cnt;
      keys = '0;
      lat = 0;
      seen = 1'b0;
      for (int i = 1; i <= 4*FR + 2 && !seen; i++) begin
         tick(1);
         if (!key_down) begin seen = 1'b1; lat = i; end
      end
      chk("t3_released", {31'd0, seen}, 32'd1);
      chk("t3_not_early", {31'd0, (lat > 2*FR)}, 32'd1);
      chk("t3_code_kept", {28'd0, key_code}, 32'h3);
      chk("t3_keypad_out", {28'd0, keypad_out}, 32'h0);
      tick(FR);
      chk("t3_no_valid", valid_cnt - v0, 32'd0);
      $display("txn: release (0,3) after %0d cycles", lat);

      // 4. Bouncing (3,0), then stable.
      tick(2*FR);
      v0 = valid_cnt;
      for (int i = 0; i < 6; i++) begin
         keys[12] = ~keys[12];
         tick(20);
      end
      keys[12] = 1'b0;
      chk("t4_bounce_no_valid", valid_cnt - v0, 32'd0);
      keys[12] = 1'b1;
      tick(6*FR);
      chk("t4_one_valid", valid_cnt - v0, 32'd1);
      chk("t4_key_code", {28'd0, key_code}, 32'hC);
      $display("txn: bounce then hold (3,0)");

      // 5. Multi-key press.
      keys = '0;
      tick(6*FR);
      v0 = valid_cnt;
      keys[3]  = 1'b1;
      keys[12] = 1'b1;
      any_out = 1'b0;
      for (int i = 0; i < 10*FR; i++) begin
         tick(1);
         if (keypad_out != 4'd0) any_out = 1'b1;
      end
      chk("t5_multi_no_valid", valid_cnt - v0, 32'd0);
      chk("t5_multi_out_zero", {31'd0, any_out}, 32'd0);
      keys[12] = 1'b0;
      tick(6*FR);
      chk("t5_single_valid", valid_cnt - v0, 32'd1);
      chk("t5_key_code", {28'd0, key_code}, 32'h3);
      $display("txn: multi-key then (0,3)");

      // 6. One-frame glitch while held, then reset during debounce.
      keys = '0;
      tick(6*FR);
      keys[12] = 1'b1;
      tick(6*FR);
      chk("t6_held_code", {28'd0, key_code}, 32'hC);
      v0 = valid_cnt;
      all_down = 1'b1;
      keys[12] = 1'b0;
      for (int i = 0; i < FR; i++) begin tick(1); all_down &= key_down; end
      keys[12] = 1'b1;
      for (int i = 0; i < 4*FR; i++) begin tick(1); all_down &= key_down; end
      chk("t6_glitch_held", {31'd0, all_down}, 32'd1);
      chk("t6_glitch_no_valid", valid_cnt - v0, 32'd0);
      keys = '0;
      tick(6*FR);
      v0 = valid_cnt;
      keys[6] = 1'b1;
      tick(2*FR);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      keys = '0;
      tick(6*FR);
      chk("t6_rst_no_valid", valid_cnt - v0, 32'd0);
      chk("t6_rst_code", {28'd0, key_code}, 32'h0);
      $display("txn: glitch and reset during debounce");

      // Randomised traffic checked by the per-cycle model.
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            tick($urandom_range(1, 3));
            rst = 1'b0;
         end
         k1 = $urandom_range(0, 15);
         k2 = $urandom_range(0, 15);
         case ($urandom_range(0, 3))
            0:       keys = '0;
            3:       begin keys = '0; keys[k1] = 1'b1; keys[k2] = 1'b1; end
            default: begin keys = '0; keys[k1] = 1'b1; end
         endcase
         hold = $urandom_range(8, 120);
         $display("txn %0d: keys=%h hold=%0d", t, keys, hold);
         tick(hold);
      end
      keys = '0;
      tick(6*FR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
